// File: rtl/oled_stream.sv
// oled_stream: SSD1306 power-up, init command ROM and continuous frame
// streaming over 4-wire SPI mode 0, with row/col/place scan for the renderer.
module oled_stream #(
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned RST_HOLD = 1000,
    parameter int unsigned RST_WAIT = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    output logic [2:0] row,
    output logic [6:0] col,
    output logic [2:0] place,
    output logic       dc,
    output logic       sclk,
    output logic       mosi,
    output logic       cs_n,
    output logic       oled_rst_n,
    output logic       ready
);

    typedef enum logic [1:0] {
        S_HOLD,
        S_WAIT,
        S_INIT,
        S_STREAM
    } state_t;

    localparam logic [8:0]  PH_LAST   = 9'(2 * CLK_DIV - 1);
    localparam logic [8:0]  PH_HI     = 9'(CLK_DIV);
    localparam logic [31:0] HOLD_LAST = 32'(RST_HOLD - 1);
    localparam logic [31:0] WAIT_LAST = 32'(RST_WAIT - 1);

    state_t      state_q;
    logic [31:0] cnt_q;
    logic [8:0]  ph_q;
    logic [8:0]  ph_d;
    logic        ph_wrap;
    logic [2:0]  byte_q;
    logic [2:0]  bit_q;
    logic [2:0]  row_q;
    logic [6:0]  col_q;
    logic [2:0]  place_q;
    logic        dc_q;
    logic        sclk_q;
    logic        cs_n_q;
    logic        orst_n_q;
    logic        ready_q;
    logic [7:0]  rom_byte;

    function automatic logic [7:0] rom(input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = 8'hAE;
            3'd1:    b = 8'h8D;
            3'd2:    b = 8'h14;
            3'd3:    b = 8'h20;
            3'd4:    b = 8'h00;
            3'd5:    b = 8'hA1;
            3'd6:    b = 8'hC8;
            default: b = 8'hAF;
        endcase
        return b;
    endfunction

    assign rom_byte = rom(byte_q);
    assign ph_wrap  = (ph_q == PH_LAST);
    assign ph_d     = ph_wrap ? 9'd0 : ph_q + 9'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_HOLD;
            cnt_q    <= '0;
            ph_q     <= '0;
            byte_q   <= '0;
            bit_q    <= '0;
            row_q    <= '0;
            col_q    <= '0;
            place_q  <= '0;
            dc_q     <= 1'b0;
            sclk_q   <= 1'b0;
            cs_n_q   <= 1'b1;
            orst_n_q <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            case (state_q)
                S_HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        state_q  <= S_WAIT;
                        cnt_q    <= '0;
                        orst_n_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == WAIT_LAST) begin
                        state_q <= S_INIT;
                        cnt_q   <= '0;
                        ph_q    <= '0;
                        cs_n_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                S_INIT: begin
                    ph_q   <= ph_d;
                    sclk_q <= (ph_d >= PH_HI);
                    if (ph_wrap) begin
                        bit_q <= bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            byte_q <= byte_q + 3'd1;
                            // last ROM bit: next bit is stream byte 0
                            if (byte_q == 3'd7) begin
                                state_q <= S_STREAM;
                                dc_q    <= 1'b1;
                                ready_q <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    ph_q   <= ph_d;
                    sclk_q <= (ph_d >= PH_HI);
                    if (ph_wrap) begin
                        place_q <= place_q + 3'd1;
                        if (place_q == 3'd7) begin
                            col_q <= col_q + 7'd1;
                            if (col_q == 7'd127) begin
                                row_q <= row_q + 3'd1;
                            end
                        end
                    end
                end
            endcase
        end
    end

    always_comb begin
        mosi = 1'b0;
        case (state_q)
            S_INIT:   mosi = rom_byte[3'd7 - bit_q];
            S_STREAM: mosi = data[3'd7 - place_q];
            default:  mosi = 1'b0;
        endcase
    end

    assign row        = row_q;
    assign col        = col_q;
    assign place      = place_q;
    assign dc         = dc_q;
    assign sclk       = sclk_q;
    assign cs_n       = cs_n_q;
    assign oled_rst_n = orst_n_q;
    assign ready      = ready_q;

endmodule
